// File: rtl/vc_arbiter.sv
// Weighted two-VC to two-destination arbiter: VC0 priority with a bounded run length,
// almost-full backpressure per destination, registered push/data path and forward counters.
module vc_arbiter #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned DEST_BIT   = 4,
    parameter int unsigned VC0_WEIGHT = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  grant_vc1_r,
    output logic                  idle_out,
    output logic [7:0]            fwd_cnt_d0,
    output logic [7:0]            fwd_cnt_d1
);

    localparam logic [3:0] WEIGHT_MAX = 4'(VC0_WEIGHT);

    typedef enum logic {
        ST_IDLE,
        ST_ARB
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_weight;
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_grant_vc1;
    logic                  r_idle;
    logic [7:0]            r_cnt_d0;
    logic [7:0]            r_cnt_d1;

    logic                  w_vc0_elig;
    logic                  w_vc1_elig;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_gnt_any;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic                  w_gnt_dest;

    // A VC is eligible only if its head word's own destination has room.
    assign w_vc0_elig = !vc0_empty &&
                        !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    assign w_vc1_elig = !vc1_empty &&
                        !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

    // Grants depend on the state only, so the cycle in which enable drops
    // (last ARB cycle) may still pop one word; that word is pushed next cycle.
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (r_state == ST_IDLE) begin
            if (enable) w_next_state = ST_ARB;
        end else begin
            if (!enable) w_next_state = ST_IDLE;
            if (w_vc1_elig && ((r_weight == WEIGHT_MAX) || !w_vc0_elig))
                w_gnt1 = 1'b1;
            else if (w_vc0_elig)
                w_gnt0 = 1'b1;
        end
    end

    assign w_gnt_any  = w_gnt0 || w_gnt1;
    assign w_gnt_data = w_gnt1 ? vc1_data : vc0_data;
    assign w_gnt_dest = w_gnt_data[DEST_BIT];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_weight    <= '0;
            r_push_d0   <= 1'b0;
            r_push_d1   <= 1'b0;
            r_data      <= '0;
            r_grant_vc1 <= 1'b0;
            r_idle      <= 1'b1;
            r_cnt_d0    <= '0;
            r_cnt_d1    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_push_d0 <= w_gnt_any && !w_gnt_dest;
            r_push_d1 <= w_gnt_any &&  w_gnt_dest;
            r_idle    <= ((r_state == ST_IDLE) || !w_gnt_any) && vc0_empty && vc1_empty;
            if (w_gnt_any) begin
                r_data      <= w_gnt_data;
                r_grant_vc1 <= w_gnt1;
                if (w_gnt_dest) r_cnt_d1 <= r_cnt_d1 + 8'd1;
                else            r_cnt_d0 <= r_cnt_d0 + 8'd1;
            end
            if (w_gnt1)
                r_weight <= '0;
            else if (w_gnt0 && w_vc1_elig && (r_weight != WEIGHT_MAX))
                r_weight <= r_weight + 4'd1;
        end
    end

    assign pop_vc0     = w_gnt0 && reset_L;
    assign pop_vc1     = w_gnt1 && reset_L;
    assign push_d0     = r_push_d0;
    assign push_d1     = r_push_d1;
    assign data_out    = r_data;
    assign grant_vc1_r = r_grant_vc1;
    assign idle_out    = r_idle;
    assign fwd_cnt_d0  = r_cnt_d0;
    assign fwd_cnt_d1  = r_cnt_d1;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: a per-cycle vector table for arbitration/backpressure/enable,
// plus hand sequences for reset mid-transfer, a four-word VC0 stream and counter wrap.
module tb_vc_arbiter;

    logic       clk;
    logic       reset_L;
    logic       enable;
    logic       vc0_empty;
    logic       vc1_empty;
    logic [5:0] vc0_data;
    logic [5:0] vc1_data;
    logic       d0_almost_full;
    logic       d1_almost_full;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       push_d0;
    logic       push_d1;
    logic [5:0] data_out;
    logic       grant_vc1_r;
    logic       idle_out;
    logic [7:0] fwd_cnt_d0;
    logic [7:0] fwd_cnt_d1;

    int checks = 0;
    int errors = 0;

    vc_arbiter #(
        .DATA_WIDTH(6),
        .DEST_BIT  (4),
        .VC0_WEIGHT(3)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .enable        (enable),
        .vc0_empty     (vc0_empty),
        .vc1_empty     (vc1_empty),
        .vc0_data      (vc0_data),
        .vc1_data      (vc1_data),
        .d0_almost_full(d0_almost_full),
        .d1_almost_full(d1_almost_full),
        .pop_vc0       (pop_vc0),
        .pop_vc1       (pop_vc1),
        .push_d0       (push_d0),
        .push_d1       (push_d1),
        .data_out      (data_out),
        .grant_vc1_r   (grant_vc1_r),
        .idle_out      (idle_out),
        .fwd_cnt_d0    (fwd_cnt_d0),
        .fwd_cnt_d1    (fwd_cnt_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, e0, e1;
        logic [5:0] d0, d1;
        logic       af0, af1;
        logic       p0, p1;
        logic       q0, q1;
        logic [5:0] dout;
        logic       g1, idle;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, e0, e1, input logic [5:0] d0, d1,
                       input logic af0, af1, p0, p1, q0, q1,
                       input logic [5:0] dout, input logic g1, idle);
        vec_t v;
        v.en = en; v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
        v.af0 = af0; v.af1 = af1; v.p0 = p0; v.p1 = p1;
        v.q0 = q0; v.q1 = q1; v.dout = dout; v.g1 = g1; v.idle = idle;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, e0, e1, input logic [5:0] d0, d1,
                         input logic af0, af1);
        @(negedge clk);
        enable = en; vc0_empty = e0; vc1_empty = e1;
        vc0_data = d0; vc1_data = d1;
        d0_almost_full = af0; d1_almost_full = af1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        enable = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = '0; vc1_data = '0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_push_d0"}, push_d0, 0);
        chk({tag, "_push_d1"}, push_d1, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_g1"}, grant_vc1_r, 0);
        chk({tag, "_idle"}, idle_out, 1);
        chk({tag, "_cnt0"}, fwd_cnt_d0, 0);
        chk({tag, "_cnt1"}, fwd_cnt_d1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c0;
        int exp_c1;
        logic [5:0] w2 [4];
        logic [5:0] prev;

        reset_L = 1'b1;
        do_reset();
        #1;
        chk_reset_state("rst");

        // en e0 e1 vc0  vc1  af0 af1 | p0 p1 q0 q1 dout g1 idle
        add(1,0,0,6'h01,6'h12,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h01,6'h12,0,0, 1,0, 0,0,6'h00,0,0);
        add(1,0,0,6'h02,6'h12,0,0, 1,0, 1,0,6'h01,0,0);
        add(1,0,0,6'h03,6'h12,0,0, 1,0, 1,0,6'h02,0,0);
        add(1,0,0,6'h04,6'h12,0,0, 0,1, 1,0,6'h03,0,0);
        add(1,0,0,6'h04,6'h13,0,0, 1,0, 0,1,6'h12,1,0);
        add(1,0,0,6'h05,6'h13,0,0, 1,0, 1,0,6'h04,0,0);
        add(1,0,0,6'h06,6'h13,0,0, 1,0, 1,0,6'h05,0,0);
        add(1,0,0,6'h07,6'h13,0,0, 0,1, 1,0,6'h06,0,0);
        add(1,0,0,6'h07,6'h14,1,0, 0,1, 0,1,6'h13,1,0);
        add(1,0,0,6'h07,6'h15,1,0, 0,1, 0,1,6'h14,1,0);
        add(1,0,0,6'h07,6'h16,0,0, 1,0, 0,1,6'h15,1,0);
        add(1,1,1,6'h08,6'h16,0,0, 0,0, 1,0,6'h07,0,0);
        add(1,1,1,6'h08,6'h16,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h09,6'h17,0,1, 1,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h0A,6'h17,0,1, 1,0, 1,0,6'h09,0,0);
        add(1,0,0,6'h0B,6'h17,0,0, 1,0, 1,0,6'h0A,0,0);
        add(1,0,0,6'h0C,6'h17,0,0, 1,0, 1,0,6'h0B,0,0);
        add(1,0,0,6'h0D,6'h17,0,0, 0,1, 1,0,6'h0C,0,0);
        add(1,1,1,6'h0D,6'h17,0,0, 0,0, 0,1,6'h17,1,0);
        add(1,1,1,6'h0D,6'h17,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h0E,6'h18,1,1, 0,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h0E,6'h18,1,1, 0,0, 0,0,6'h00,0,0);
        add(0,0,1,6'h1F,6'h18,0,0, 1,0, 0,0,6'h00,0,0);
        add(0,0,1,6'h1F,6'h18,0,0, 0,0, 0,1,6'h1F,0,0);
        add(0,0,1,6'h1F,6'h18,0,0, 0,0, 0,0,6'h00,0,0);
        add(0,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h00,0,0);
        add(0,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h00,0,1);
        add(1,0,0,6'h1A,6'h03,0,1, 0,1, 0,0,6'h00,0,1);
        add(1,1,1,6'h00,6'h00,0,0, 0,0, 1,0,6'h03,1,0);
        add(1,1,1,6'h00,6'h00,0,0, 0,0, 0,0,6'h00,0,1);

        exp_c0 = 0;
        exp_c1 = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].e0, vecs[i].e1, vecs[i].d0, vecs[i].d1,
                  vecs[i].af0, vecs[i].af1);
            if (vecs[i].q0) exp_c0++;
            if (vecs[i].q1) exp_c1++;
            chk($sformatf("v%0d_pop0", i), pop_vc0, vecs[i].p0);
            chk($sformatf("v%0d_pop1", i), pop_vc1, vecs[i].p1);
            chk($sformatf("v%0d_push0", i), push_d0, vecs[i].q0);
            chk($sformatf("v%0d_push1", i), push_d1, vecs[i].q1);
            chk($sformatf("v%0d_idle", i), idle_out, vecs[i].idle);
            chk($sformatf("v%0d_cnt0", i), fwd_cnt_d0, 32'(exp_c0 % 256));
            chk($sformatf("v%0d_cnt1", i), fwd_cnt_d1, 32'(exp_c1 % 256));
            if (vecs[i].q0 || vecs[i].q1) begin
                chk($sformatf("v%0d_data", i), data_out, vecs[i].dout);
                chk($sformatf("v%0d_g1", i), grant_vc1_r, vecs[i].g1);
            end
        end

        // Reset asserted in a cycle that pops VC0, with a push already in flight.
        do_reset();
        drive(1, 0, 1, 6'h01, 6'h00, 0, 0);
        chk("r1_idle_pop", pop_vc0, 0);
        drive(1, 0, 1, 6'h01, 6'h00, 0, 0);
        chk("r1_pop_a", pop_vc0, 1);
        drive(1, 0, 1, 6'h02, 6'h00, 0, 0);
        chk("r1_pop_b", pop_vc0, 1);
        chk("r1_push_a", push_d0, 1);
        reset_L = 1'b0;
        #1;
        chk("r1_pop_forced", pop_vc0, 0);
        chk_reset_state("r1_async");
        @(negedge clk);
        reset_L = 1'b1;
        enable = 1'b0; vc0_empty = 1'b1;
        #1;
        chk_reset_state("r1_rel");
        drive(0, 1, 1, 6'h00, 6'h00, 0, 0);
        chk("r1_no_push0", push_d0, 0);
        chk("r1_no_push1", push_d1, 0);

        // VC0-only stream of four words alternating destinations.
        do_reset();
        w2[0] = 6'h05; w2[1] = 6'h15; w2[2] = 6'h06; w2[3] = 6'h16;
        drive(1, 0, 1, w2[0], 6'h00, 0, 0);
        chk("s2_idle_pop", pop_vc0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, w2[k], 6'h00, 0, 0);
            chk($sformatf("s2_pop0_%0d", k), pop_vc0, 1);
            chk($sformatf("s2_pop1_%0d", k), pop_vc1, 0);
            if (k > 0) begin
                chk($sformatf("s2_push0_%0d", k), push_d0, (k % 2 == 1) ? 1 : 0);
                chk($sformatf("s2_push1_%0d", k), push_d1, (k % 2 == 0) ? 1 : 0);
                chk($sformatf("s2_data_%0d", k), data_out, w2[k-1]);
            end
        end
        drive(1, 1, 1, 6'h00, 6'h00, 0, 0);
        chk("s2_last_push1", push_d1, 1);
        chk("s2_last_data", data_out, w2[3]);
        chk("s2_cnt0", fwd_cnt_d0, 2);
        chk("s2_cnt1", fwd_cnt_d1, 2);

        // 256 words to D1: counter wraps exactly once, no lost or extra push.
        do_reset();
        drive(1, 1, 0, 6'h00, 6'h10, 0, 0);
        chk("s6_idle_pop", pop_vc1, 0);
        prev = '0;
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 0, 6'h00, 6'h10 | 6'(i % 16), 0, 0);
            chk($sformatf("s6_pop1_%0d", i), pop_vc1, 1);
            if (i > 0) begin
                chk($sformatf("s6_push1_%0d", i), push_d1, 1);
                chk($sformatf("s6_data_%0d", i), data_out, prev);
            end
            chk($sformatf("s6_cnt1_%0d", i), fwd_cnt_d1, 32'(i));
            prev = 6'h10 | 6'(i % 16);
        end
        drive(1, 1, 1, 6'h00, 6'h00, 0, 0);
        chk("s6_last_push1", push_d1, 1);
        chk("s6_last_data", data_out, prev);
        chk("s6_wrap", fwd_cnt_d1, 0);
        chk("s6_cnt0", fwd_cnt_d0, 0);
        drive(1, 1, 1, 6'h00, 6'h00, 0, 0);
        chk("s6_no_extra", push_d1, 0);
        chk("s6_wrap_hold", fwd_cnt_d1, 0);
        chk("s6_idle", idle_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
